// File: rtl/valid_data_unloader_if.sv
// Write-strobe / valid-ready handshake bundle for valid_data_unloader.
// slave = the buffer; master = producer/consumer side.
interface valid_data_unloader_if #(
  parameter int BIT_OF_DATA = 8,
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic                   load_data;
  logic [BIT_OF_DATA-1:0] data_in;
  logic                   full;
  logic [BIT_OF_DATA-1:0] data_out;
  logic                   data_valid;
  logic                   data_ready;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   ovf_clr;

  modport master (
    output load_data,
    output data_in,
    output data_ready,
    output ovf_clr,
    input  full,
    input  data_out,
    input  data_valid,
    input  count,
    input  overflow
  );

  modport slave (
    input  load_data,
    input  data_in,
    input  data_ready,
    input  ovf_clr,
    output full,
    output data_out,
    output data_valid,
    output count,
    output overflow
  );

endinterface

// File: rtl/valid_data_unloader.sv
// First-word fall-through FIFO with valid/ready unload side.
// Sticky overflow flag only when VALID_DATA_UNLOADER_OVF_EN is defined.
module valid_data_unloader #(
  parameter int                     BIT_OF_DATA = 8,
  parameter int                     DEPTH = 4,
  parameter logic [BIT_OF_DATA-1:0] DEF_VALUE = '0
) (
  input logic                  clk,
  input logic                  rst,
  valid_data_unloader_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [BIT_OF_DATA-1:0] mem [DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [CW-1:0]          cnt;
  logic                   is_empty;
  logic                   is_full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == FULL_CNT);
  assign pop      = !is_empty && bus.data_ready;
  // A pop frees a slot in the same cycle, so full does not block it.
  assign push     = bus.load_data && (!is_full || pop);
  assign drop     = bus.load_data && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.full       = is_full;
  assign bus.data_valid = !is_empty;
  assign bus.count      = cnt;
  assign bus.data_out   = is_empty ? DEF_VALUE : mem[rd_ptr];

`ifdef VALID_DATA_UNLOADER_OVF_EN
  logic ovf_q;

  // A drop wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.overflow = ovf_q;
`else
  logic unused_ovf;

  assign unused_ovf   = bus.ovf_clr | drop;
  assign bus.overflow = 1'b0;
`endif

endmodule

// File: doc/valid_data_unloader.md
VALID_DATA_UNLOADER -- requirements
Module: valid_data_unloader

Interface
REQ-001 The block SHALL have parameter DEF_VALUE, default 0: value driven on data_out while the buffer is empty and after reset.
REQ-002 The block SHALL have parameter BIT_OF_DATA, default 8: data width.
REQ-003 The block SHALL have parameter DEPTH, default 4: number of entries, a power of two from 2 to 16.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port load_data, input, 1 bit: write strobe; 1 = capture data_in this cycle.
REQ-007 The block SHALL have port data_in, input, BIT_OF_DATA bits: write data.
REQ-008 The block SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-009 The block SHALL have port data_out, output, BIT_OF_DATA bits: oldest stored entry.
REQ-010 The block SHALL have port data_valid, output, 1 bit: high when count != 0.
REQ-011 The block SHALL have port data_ready, input, 1 bit: the consumer accepts data_out when data_valid && data_ready.
REQ-012 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-013 The block SHALL have port overflow, output, 1 bit: sticky dropped-write flag.
REQ-014 The block SHALL have port ovf_clr, input, 1 bit: clears overflow.

Function
REQ-015 The block SHALL define push = load_data && (!full || pop), where pop = data_valid && data_ready.
REQ-016 A push SHALL write data_in at the write pointer; the entry is visible on data_out, with data_valid high, in the cycle after the push edge when the buffer was empty (1-cycle latency, first-word fall-through).
REQ-017 A pop SHALL advance the read pointer; data_out then shows the next entry in the following cycle, or DEF_VALUE if the buffer is now empty.
REQ-018 While data_valid && !data_ready, data_out and data_valid SHALL hold stable.
REQ-019 data_out SHALL equal DEF_VALUE whenever count == 0.
REQ-020 count SHALL update as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-021 The pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-022 A simultaneous push and pop at full SHALL be accepted, and count SHALL stay at DEPTH.
REQ-023 A simultaneous push and pop at empty SHALL be impossible, because pop requires data_valid; the push proceeds normally.
REQ-024 A load_data while full with no pop SHALL drop the write and leave the contents unchanged.
REQ-025 A pop attempt while empty (data_ready without data_valid) SHALL have no effect.
REQ-026 The stored order SHALL be strict FIFO, with no reordering or duplication.

Reset
REQ-027 When rst = 1 at a clock edge, the block SHALL clear the pointers and count to 0 and set data_valid = 0, full = 0, data_out = DEF_VALUE and overflow = 0.
REQ-028 A reset asserted mid-operation SHALL discard all entries, and any push or pop in that cycle SHALL be ignored.
REQ-029 Reset SHALL NOT be required to clear the storage array contents.

Configuration
REQ-030 With macro VALID_DATA_UNLOADER_OVF_EN defined, overflow SHALL be set at the edge after a dropped write (REQ-024), remain set until ovf_clr = 1 at an edge, and, if a drop and ovf_clr occur in the same cycle, remain set.
REQ-031 With VALID_DATA_UNLOADER_OVF_EN undefined, overflow SHALL be constant 0, ovf_clr SHALL be ignored, and no overflow register SHALL be built.

Verification
REQ-032 The bench SHALL cover: DEPTH=4, reset then load 0x11 with data_ready=0 -> next cycle data_valid=1, data_out=0x11, count=1; after 3 idle cycles, output unchanged.
REQ-033 The bench SHALL cover: load 0x01..0x04 back-to-back with data_ready=0 -> full=1, count=4; then data_ready=1 -> 0x01, 0x02, 0x03, 0x04 on consecutive cycles, then data_valid=0 and data_out=DEF_VALUE.
REQ-034 The bench SHALL cover: at full, load_data=1 with data_in=0xAA and data_ready=1 -> 0x01 popped, count stays 4, and 0xAA emerges last.
REQ-035 The bench SHALL cover: at full, load 0x55 with data_ready=0 -> 0x55 never appears; with the macro, overflow=1 until ovf_clr; without it, overflow stays 0.
REQ-036 The bench SHALL cover: 20 pushes and 20 pops interleaved randomly over 50 cycles -> output order matches input order across pointer wrap-around, and count never exceeds 4.
REQ-037 The bench SHALL cover: rst=1 while count=3 and load_data=1 -> the next cycle shows count=0, data_valid=0, data_out=DEF_VALUE and overflow=0.
